// File: rtl/load_store_unit.sv
// load_store_unit
// Byte-addressed load/store front end for the word-wide BRAM data port.
// One CPU request is taken at a time. Stores become a single write pulse with
// lane-replicated data and byte enables. Loads issue a read pulse, wait out the
// BRAM read latency, then return the extracted and extended lane. Bad requests
// (misaligned, out of range, illegal size) never touch memory. They produce an
// error response one cycle after accept.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and is held low while
// reset is asserted. While req_ready is low, all req_* inputs are ignored. The
// response is a one-cycle rsp_valid pulse. It has no backpressure.
module load_store_unit #(
   parameter int          ADDR_WIDTH   = 11,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR    = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_error,
   output logic                  mem_ren,
   output logic                  mem_wen,
   output logic [3:0]            mem_bsel,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   // Size of the data memory in bytes. Offsets at or above this value are out of range.
   localparam logic [31:0] MEM_BYTES = 32'(4) << ADDR_WIDTH;
   // WAIT lasts READ_LATENCY-1 cycles. The counter counts down to zero inside WAIT.
   localparam logic [1:0]  WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

   state_t                r_state;
   state_t                w_next;
   logic [1:0]            r_wait_cnt;
   logic [1:0]            w_wait_cnt;

   // Load attributes captured at accept. The req_* inputs are ignored afterwards.
   logic [1:0]            r_lat_lane;
   logic [1:0]            r_lat_size;
   logic                  r_lat_uns;
   logic                  w_lat_load;

   // Registered output copies and their next values
   logic                  r_rsp_valid, w_rsp_valid;
   logic [31:0]           r_rsp_rdata, w_rsp_rdata;
   logic                  r_rsp_error, w_rsp_error;
   logic                  r_mem_ren,   w_mem_ren;
   logic                  r_mem_wen,   w_mem_wen;
   logic [3:0]            r_mem_bsel,  w_mem_bsel;
   logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr;
   logic [31:0]           r_mem_wdata, w_mem_wdata;

   logic [31:0]           w_off;
   logic                  w_bad;
   logic                  w_accept;
   logic [3:0]            w_st_bsel;
   logic [31:0]           w_st_wdata;
   logic [31:0]           w_ld_data;

   assign req_ready = (r_state == S_IDLE) && !reset;
   assign w_accept  = req_valid && req_ready;

   // Decode the request address: offset into memory and legality.
   always_comb begin
      w_off = req_addr - BASE_ADDR;
      w_bad = (w_off >= MEM_BYTES)
            || (req_size == 2'b11)
            || ((req_size == 2'b01) && req_addr[0])
            || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   // Store lane placement: replicate data across lanes and enable the addressed bytes.
   always_comb begin
      w_st_bsel  = 4'b1111;
      w_st_wdata = req_wdata;
      case (req_size)
         2'b00: begin
            w_st_wdata = {4{req_wdata[7:0]}};
            w_st_bsel  = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            w_st_wdata = {2{req_wdata[15:0]}};
            w_st_bsel  = req_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            w_st_wdata = req_wdata;
            w_st_bsel  = 4'b1111;
         end
      endcase
   end

   // Load extraction: select the latched lane and extend it to 32 bits.
   always_comb begin
      logic [7:0]  v_byte;
      logic [15:0] v_half;
      v_byte = mem_rdata[7:0];
      v_half = r_lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (r_lat_lane)
         2'd0:    v_byte = mem_rdata[7:0];
         2'd1:    v_byte = mem_rdata[15:8];
         2'd2:    v_byte = mem_rdata[23:16];
         default: v_byte = mem_rdata[31:24];
      endcase
      case (r_lat_size)
         2'b00:   w_ld_data = r_lat_uns ? {24'b0, v_byte} : {{24{v_byte[7]}}, v_byte};
         2'b01:   w_ld_data = r_lat_uns ? {16'b0, v_half} : {{16{v_half[15]}}, v_half};
         default: w_ld_data = mem_rdata;
      endcase
   end

   // Next-state and next-output logic. Pulses default low and are set for one cycle.
   always_comb begin
      w_next      = r_state;
      w_wait_cnt  = r_wait_cnt;
      w_lat_load  = 1'b0;
      w_rsp_valid = 1'b0;
      w_rsp_rdata = 32'h0;
      w_rsp_error = 1'b0;
      w_mem_ren   = 1'b0;
      w_mem_wen   = 1'b0;
      w_mem_bsel  = 4'h0;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = 32'h0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_bad) begin
                  w_next      = S_ERR;
                  w_rsp_valid = 1'b1;
                  w_rsp_error = 1'b1;
               end else if (req_we) begin
                  w_next      = S_WRITE;
                  w_mem_wen   = 1'b1;
                  w_mem_bsel  = w_st_bsel;
                  w_mem_wdata = w_st_wdata;
                  w_mem_addr  = w_off[ADDR_WIDTH+1:2];
                  w_rsp_valid = 1'b1;
               end else begin
                  w_next      = S_READ;
                  w_mem_ren   = 1'b1;
                  w_mem_addr  = w_off[ADDR_WIDTH+1:2];
                  w_lat_load  = 1'b1;
               end
            end
         end
         S_READ: begin
            if (READ_LATENCY <= 1) begin
               w_next      = S_RESP;
               w_rsp_valid = 1'b1;
               w_rsp_rdata = w_ld_data;
            end else begin
               w_next     = S_WAIT;
               w_wait_cnt = WAIT_INIT;
            end
         end
         S_WAIT: begin
            if (r_wait_cnt == 2'd0) begin
               w_next      = S_RESP;
               w_rsp_valid = 1'b1;
               w_rsp_rdata = w_ld_data;
            end else begin
               w_wait_cnt = r_wait_cnt - 2'd1;
            end
         end
         S_WRITE, S_RESP, S_ERR: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State register and latency counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= 2'd0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_cnt;
      end
   end

   // Capture load attributes at accept for use when the data returns
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lat_lane <= 2'd0;
         r_lat_size <= 2'd0;
         r_lat_uns  <= 1'b0;
      end else if (w_lat_load) begin
         r_lat_lane <= req_addr[1:0];
         r_lat_size <= req_size;
         r_lat_uns  <= req_unsigned;
      end
   end

   // Output registers: every mem_* and rsp_* output comes straight from a flop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_rsp_error <= 1'b0;
         r_mem_ren   <= 1'b0;
         r_mem_wen   <= 1'b0;
         r_mem_bsel  <= 4'h0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'h0;
      end else begin
         r_rsp_valid <= w_rsp_valid;
         r_rsp_rdata <= w_rsp_rdata;
         r_rsp_error <= w_rsp_error;
         r_mem_ren   <= w_mem_ren;
         r_mem_wen   <= w_mem_wen;
         r_mem_bsel  <= w_mem_bsel;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;
   assign mem_ren   = r_mem_ren;
   assign mem_wen   = r_mem_wen;
   assign mem_bsel  = r_mem_bsel;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit (ADDR_WIDTH=11, READ_LATENCY=3, BASE_ADDR=0).
module tb_load_store_unit;

   localparam int          AW        = 11;
   localparam int          RL        = 3;
   localparam logic [31:0] BASE      = 32'h0;
   localparam logic [31:0] MEM_BYTES = 32'h2000;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_error;
   logic          mem_ren;
   logic          mem_wen;
   logic [3:0]    mem_bsel;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   int n_cmp  = 0;
   int n_fail = 0;

   // Observations from the most recent transaction, for directed checks
   logic [31:0] o_addr, o_bsel, o_wd, o_rd;
   logic        o_err;

   load_store_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_bsel(mem_bsel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: expected memory-side and response values from the request rules
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] d, input logic [31:0] rdata,
                        output logic err, output logic [31:0] e_addr, output logic [31:0] e_bsel,
                        output logic [31:0] e_wd, output logic [31:0] e_rd);
      logic [31:0] off;
      int          lane;
      logic [31:0] v;
      off  = addr - BASE;
      lane = int'(addr % 4);
      err  = (off >= MEM_BYTES) || (size == 2'd3) ||
             (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && lane != 0);
      e_addr = (off / 4) % (1 << AW);
      e_bsel = 32'hF;
      e_wd   = d;
      e_rd   = 32'h0;
      if (size == 2'd0) begin
         e_wd   = (d & 32'hFF) * 32'h01010101;
         e_bsel = 32'h1 << lane;
      end else if (size == 2'd1) begin
         e_wd   = (d & 32'hFFFF) * 32'h00010001;
         e_bsel = (lane >= 2) ? 32'hC : 32'h3;
      end
      if (!we && !err) begin
         if (size == 2'd0) begin
            v = (rdata >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
         end else if (size == 2'd1) begin
            v = (rdata >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
         end else begin
            v = rdata;
         end
         e_rd = v;
      end
   endtask

   // Drive junk on the request inputs (must be ignored while busy)
   task automatic drive_junk();
      req_valid    = 1'b1;
      req_we       = 1'($urandom_range(0, 1));
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr     = $urandom;
      req_wdata    = $urandom;
   endtask

   // Issue one request and check every cycle until the unit is ready again
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] d, input logic [31:0] rdata);
      logic        err;
      logic [31:0] e_addr, e_bsel, e_wd, e_rd;
      int          rsp_k, last;
      logic        exp_ren, exp_wen;
      model(we, size, uns, addr, d, rdata, err, e_addr, e_bsel, e_wd, e_rd);
      o_addr = 'x; o_bsel = 'x; o_wd = 'x; o_rd = 'x; o_err = 1'bx;
      @(negedge clk);
      check("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = d; mem_rdata = rdata;
      @(posedge clk);
      rsp_k = (err || we) ? 1 : RL + 1;
      last  = rsp_k + 1;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         exp_ren = (k == 1) && !err && !we;
         exp_wen = (k == 1) && !err && we;
         check("mem_ren", 32'(mem_ren), 32'(exp_ren));
         check("mem_wen", 32'(mem_wen), 32'(exp_wen));
         check("rsp_valid", 32'(rsp_valid), 32'(k == rsp_k));
         check("req_ready", 32'(req_ready), 32'(k == last));
         if (k == rsp_k) begin
            check("rsp_error", 32'(rsp_error), 32'(err));
            check("rsp_rdata", rsp_rdata, e_rd);
            o_err = rsp_error; o_rd = rsp_rdata;
         end
         if (exp_wen) begin
            check("wr_bsel", 32'(mem_bsel), e_bsel);
            check("wr_wdata", mem_wdata, e_wd);
            check("wr_addr", 32'(mem_addr), e_addr);
            o_addr = 32'(mem_addr); o_bsel = 32'(mem_bsel); o_wd = mem_wdata;
         end else begin
            check("idle_bsel", 32'(mem_bsel), 32'h0);
            check("idle_wdata", mem_wdata, 32'h0);
         end
         if (exp_ren) begin
            check("rd_addr", 32'(mem_addr), e_addr);
            o_addr = 32'(mem_addr);
         end
         if (k < last) drive_junk();
         else req_valid = 1'b0;
      end
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          sel;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0;

      // Reset state
      #2;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_ren_wen", {30'b0, mem_ren, mem_wen}, 32'd0);
      check("rst_bsel", 32'(mem_bsel), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Stores
      do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0);
      check("t1_addr", o_addr, 32'h040);
      check("t1_bsel", o_bsel, 32'hF);
      check("t1_wdata", o_wd, 32'hDEADBEEF);
      do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 32'h0);
      check("t2_byte_wdata", o_wd, 32'hA5A5A5A5);
      check("t2_byte_bsel", o_bsel, 32'h8);
      do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234, 32'h0);
      check("t2_half_wdata", o_wd, 32'h12341234);
      check("t2_half_bsel", o_bsel, 32'hC);

      // Loads
      do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233);
      check("t3_sbyte", o_rd, 32'hFFFFFF80);
      do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233);
      check("t3_ubyte", o_rd, 32'h00000080);
      do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h8001FFFF);
      check("t4_uhalf", o_rd, 32'h00008001);
      do_req(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'h8001FFFF);
      check("t4_shalf", o_rd, 32'hFFFFFFFF);

      // Error paths and the last legal word
      do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h12345678);
      check("t5_word_mis", 32'(o_err), 32'd1);
      do_req(1'b1, 2'd1, 1'b0, 32'h101, 32'h5555, 32'h0);
      check("t5_half_mis", 32'(o_err), 32'd1);
      do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h12345678);
      check("t5_size11", 32'(o_err), 32'd1);
      do_req(1'b1, 2'd0, 1'b0, 32'h2000, 32'h77, 32'h0);
      check("t5_range", 32'(o_err), 32'd1);
      do_req(1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0, 32'hCAFEF00D);
      check("t5_last_err", 32'(o_err), 32'd0);
      check("t5_last_addr", o_addr, 32'h7FF);
      check("t5_last_data", o_rd, 32'hCAFEF00D);

      // Randomized requests against the model
      for (int i = 0; i < 150; i++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      a = $urandom;
         else if (sel == 1) a = 32'h1FFC + $urandom_range(0, 7);
         else               a = $urandom_range(0, 32'h1FFF);
         sel = int'($urandom_range(0, 9));
         sz  = (sel == 9) ? 2'd3 : 2'(sel % 3);
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom);
      end

      // Reset while a load waits for data: discarded, no response afterwards
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h100; mem_rdata = 32'h13579BDF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("r6_ren", 32'(mem_ren), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("r6_ready_in_rst", 32'(req_ready), 32'd0);
      check("r6_rsp_in_rst", {29'b0, rsp_valid, rsp_error, mem_ren}, 32'd0);
      check("r6_rdata_in_rst", rsp_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("r6_ready_after", 32'(req_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("r6_no_rsp", 32'(rsp_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
